// File: rtl/register_file_if.sv
// register_file_if: read, write and clear port bundle of the multi-port register file
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        read_en;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rvalid;
    logic                     write_en;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic                     clear_req;
    logic                     busy;
    modport master (output read_en, raddr, write_en, waddr, wdata, clear_req, input rdata, rvalid, busy);
    modport slave (input read_en, raddr, write_en, waddr, wdata, clear_req, output rdata, rvalid, busy);
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-read-port register file with registered reads,
// optional write bypass, optional hard-wired zero entry and a sequenced bulk-clear engine
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    register_file_if.slave bus
);
    localparam logic [0:0]        IDLE     = 1'b0;
    localparam logic [0:0]        CLEAR    = 1'b1;
    localparam int                DEPTH_M1 = DEPTH - 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST     = DEPTH_M1[ADDR_W-1:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              busy;
    logic              wr_ok;

    // an address is live when it maps to a real, writable entry
    function automatic logic live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign busy     = state == CLEAR;
    assign bus.busy = busy;
    assign wr_ok    = bus.write_en && !busy && live(bus.waddr);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            state <= bus.clear_req ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= cnt == LAST ? IDLE : CLEAR;
            cnt   <= cnt + 1'b1;
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        else if (busy)
            mem[cnt] <= '0;
        else if (wr_ok)
            mem[bus.waddr] <= bus.wdata;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] rd_q;
        logic              rv_q;
        assign ra = bus.raddr[i*ADDR_W +: ADDR_W];
        always_comb rd_d = !live(ra) ? '0 : (BYPASS != 0 && wr_ok && ra == bus.waddr) ? bus.wdata : mem[ra];
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rv_q <= bus.read_en[i] && !busy;
                if (bus.read_en[i] && !busy) rd_q <= rd_d;
            end
        assign bus.rdata[i*DATA_W +: DATA_W] = rd_q;
        assign bus.rvalid[i]                 = rv_q;
    end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: scoreboard bench; dut_a uses defaults, dut_b is DEPTH=20 with zero entry and no bypass
module tb_register_file_mp;
    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic [1:0]  read_en   = '0;
    logic [4:0]  ra0       = '0;
    logic [4:0]  ra1       = '0;
    logic [4:0]  waddr     = '0;
    logic [31:0] wdata     = '0;
    logic        write_en  = 1'b0;
    logic        clear_req = 1'b0;
    int          n_vec     = 0;
    int          n_err     = 0;
    int          busy_a;
    int          busy_b;
    logic [31:0] qa0[$];
    logic [31:0] qa1[$];
    logic [31:0] qb0[$];
    logic [31:0] qb1[$];

    always #5 clk = ~clk;

    register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
    register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_b ();

    assign bus_a.read_en   = read_en;
    assign bus_a.raddr     = {ra1, ra0};
    assign bus_a.write_en  = write_en;
    assign bus_a.waddr     = waddr;
    assign bus_a.wdata     = wdata;
    assign bus_a.clear_req = clear_req;
    assign bus_b.read_en   = read_en;
    assign bus_b.raddr     = {ra1, ra0};
    assign bus_b.write_en  = write_en;
    assign bus_b.waddr     = waddr;
    assign bus_b.wdata     = wdata;
    assign bus_b.clear_req = clear_req;

    register_file_mp dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    register_file_mp #(.DEPTH(20), .ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] d, input int sz, input logic [31:0] e);
        if (sz == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected rvalid with rdata %h, no read outstanding", nm, d);
        end else cmp(nm, d, e);
    endtask

    always @(negedge clk) begin
        int sz;
        logic [31:0] e;
        if (bus_a.rvalid[0] === 1'b1) begin
            sz = qa0.size(); e = sz > 0 ? qa0.pop_front() : '0; pop_chk("a.rdata0", bus_a.rdata[31:0], sz, e);
        end
        if (bus_a.rvalid[1] === 1'b1) begin
            sz = qa1.size(); e = sz > 0 ? qa1.pop_front() : '0; pop_chk("a.rdata1", bus_a.rdata[63:32], sz, e);
        end
        if (bus_b.rvalid[0] === 1'b1) begin
            sz = qb0.size(); e = sz > 0 ? qb0.pop_front() : '0; pop_chk("b.rdata0", bus_b.rdata[31:0], sz, e);
        end
        if (bus_b.rvalid[1] === 1'b1) begin
            sz = qb1.size(); e = sz > 0 ? qb1.pop_front() : '0; pop_chk("b.rdata1", bus_b.rdata[63:32], sz, e);
        end
    end

    task automatic op(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [1:0] re, input logic [4:0] r0, input logic [4:0] r1, input logic clr);
        write_en = we; waddr = wa; wdata = wd; read_en = re; ra0 = r0; ra1 = r1; clear_req = clr;
        @(posedge clk); #1;
        write_en = 1'b0; read_en = '0; clear_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        op(1'b1, a, d, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] re, input logic [4:0] r0, input logic [4:0] r1);
        op(1'b0, '0, '0, re, r0, r1, 1'b0);
    endtask

    task automatic mem_zero(input string tag);
        for (int k = 0; k < 32; k++) cmp($sformatf("%s a.mem[%0d]", tag, k), dut_a.mem[k], '0);
        for (int k = 0; k < 20; k++) cmp($sformatf("%s b.mem[%0d]", tag, k), dut_b.mem[k], '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 reset_n = 1'b0;
        idle(2);
        mem_zero("reset");
        cmp("reset a.rvalid", {30'b0, bus_a.rvalid}, '0);
        cmp("reset a.busy", {31'b0, bus_a.busy}, '0);
        cmp("reset a.rdata0", bus_a.rdata[31:0], '0);
        cmp("reset b.busy", {31'b0, bus_b.busy}, '0);
        reset_n = 1'b1;
        idle(1);
        // basic write then read
        wr(5'd5, 32'hDEADBEEF);
        qa0.push_back(32'hDEADBEEF); qb0.push_back(32'hDEADBEEF);
        rd(2'b01, 5'd5, 5'd0);
        // same-cycle write and read on two ports: bypass vs pre-write contents
        wr(5'd9, 32'h5555);
        qa0.push_back(32'h1234); qa1.push_back(32'h1234);
        qb0.push_back(32'h5555); qb1.push_back(32'h5555);
        op(1'b1, 5'd9, 32'h1234, 2'b11, 5'd9, 5'd9, 1'b0);
        qa0.push_back(32'h1234); qa1.push_back(32'h1234);
        qb0.push_back(32'h1234); qb1.push_back(32'h1234);
        rd(2'b11, 5'd9, 5'd9);
        idle(1);
        cmp("idle a.rvalid", {30'b0, bus_a.rvalid}, '0);
        cmp("hold a.rdata1", bus_a.rdata[63:32], 32'h1234);
        cmp("hold b.rdata0", bus_b.rdata[31:0], 32'h1234);
        // zero entry
        wr(5'd0, 32'hFFFF_FFFF);
        qa0.push_back(32'hFFFF_FFFF); qa1.push_back(32'hDEADBEEF);
        qb0.push_back(32'h0);         qb1.push_back(32'hDEADBEEF);
        rd(2'b11, 5'd0, 5'd5);
        cmp("b.mem[0] zero", dut_b.mem[0], '0);
        cmp("a.mem[0] written", dut_a.mem[0], 32'hFFFF_FFFF);
        // addresses beyond dut_b depth
        wr(5'd25, 32'hC0FFEE);
        qa0.push_back(32'hC0FFEE); qb0.push_back(32'h0);
        rd(2'b01, 5'd25, 5'd0);
        qa0.push_back(32'hBEE); qb0.push_back(32'h0);
        op(1'b1, 5'd26, 32'hBEE, 2'b01, 5'd26, 5'd0, 1'b0);
        // fill, then bulk clear
        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i + 1));
        qa0.push_back(32'd4);  qb0.push_back(32'd4);
        qa1.push_back(32'd20); qb1.push_back(32'd20);
        rd(2'b11, 5'd3, 5'd19);
        op(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
        busy_a = 0;
        busy_b = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus_a.busy) busy_a++;
            if (bus_b.busy) busy_b++;
            if (k == 5) begin
                op(1'b1, 5'd3, 32'hAA, 2'b11, 5'd3, 5'd3, 1'b0);
                cmp("busy a.rvalid", {30'b0, bus_a.rvalid}, '0);
                cmp("busy b.rvalid", {30'b0, bus_b.rvalid}, '0);
                cmp("busy a.rdata0 hold", bus_a.rdata[31:0], 32'd4);
            end else idle(1);
        end
        cmp("a busy cycles", busy_a, 32'd32);
        cmp("b busy cycles", busy_b, 32'd20);
        mem_zero("clear");
        // clear together with a write and a read
        wr(5'd4, 32'h44);
        qa0.push_back(32'h44); qb0.push_back(32'h44);
        op(1'b1, 5'd10, 32'h1010, 2'b01, 5'd4, 5'd0, 1'b1);
        cmp("clr+wr a.mem[10]", dut_a.mem[10], 32'h1010);
        cmp("clr+wr b.mem[10]", dut_b.mem[10], 32'h1010);
        cmp("clr+wr a.busy", {31'b0, bus_a.busy}, 32'd1);
        idle(40);
        cmp("after clr a.mem[10]", dut_a.mem[10], '0);
        cmp("after clr b.mem[10]", dut_b.mem[10], '0);
        cmp("after clr a.mem[4]", dut_a.mem[4], '0);
        cmp("after clr a.busy", {31'b0, bus_a.busy}, '0);
        // reset during clear
        wr(5'd7, 32'h77);
        op(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
        idle(10);
        cmp("mid clr a.busy", {31'b0, bus_a.busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        cmp("rst a.busy", {31'b0, bus_a.busy}, '0);
        cmp("rst b.busy", {31'b0, bus_b.busy}, '0);
        cmp("rst a.rdata0", bus_a.rdata[31:0], '0);
        mem_zero("rst");
        @(posedge clk); #1 reset_n = 1'b1;
        op(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
        cmp("new clr a.busy", {31'b0, bus_a.busy}, 32'd1);
        cmp("new clr b.busy", {31'b0, bus_b.busy}, 32'd1);
        idle(35);
        cmp("done a.busy", {31'b0, bus_a.busy}, '0);
        cmp("done b.busy", {31'b0, bus_b.busy}, '0);
        idle(2);
        cmp("qa0 drained", qa0.size(), '0);
        cmp("qa1 drained", qa1.size(), '0);
        cmp("qb0 drained", qb0.size(), '0);
        cmp("qb1 drained", qb1.size(), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
